// File: rtl/writeback_stage.sv
// writeback_stage: sole register-file write port; in_* handshake from memory stage, mem_* load response, write_* to register file, load_* hazard/error info, retired_count
module writeback_stage #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_result,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [XLEN-1:0]       write_value,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] load_rd,
  output logic                  load_error,
  output logic [31:0]           retired_count
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, lerr_q, lerr_d, lpend_q, lpend_d, rw_q, rw_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d, lrd_q, lrd_d;
  logic [XLEN-1:0] wval_q, wval_d, ext;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0] b;
  logic [15:0] h;
  logic accept, err;
  assign in_ready = state_q == IDLE;
  assign accept = in_valid && in_ready;
  assign b = mem_rdata[{off_q, 3'b000} +: 8];
  assign h = mem_rdata[{off_q[1], 4'b0000} +: 16];
  always_comb begin
    ext = f3_q == 3'd0 ? {{(XLEN-8){b[7]}}, b} :
          f3_q == 3'd1 ? {{(XLEN-16){h[15]}}, h} :
          f3_q == 3'd4 ? {{(XLEN-8){1'b0}}, b} :
          f3_q == 3'd5 ? {{(XLEN-16){1'b0}}, h} : mem_rdata;
    err = f3_q == 3'd3 || f3_q == 3'd6 || f3_q == 3'd7 ||
          ((f3_q == 3'd1 || f3_q == 3'd5) && off_q[0]) ||
          (f3_q == 3'd2 && off_q != 2'd0);
  end
  always_comb begin
    state_d = state_q;
    we_d = 1'b0;
    lerr_d = 1'b0;
    waddr_d = waddr_q;
    wval_d = wval_q;
    lpend_d = lpend_q;
    lrd_d = lrd_q;
    rw_d = rw_q;
    f3_d = f3_q;
    off_d = off_q;
    cnt_d = cnt_q;
    if (accept && !in_is_load) begin
      we_d = in_reg_write && in_rd != '0;
      waddr_d = we_d ? in_rd : waddr_q;
      wval_d = we_d ? in_result : wval_q;
      cnt_d = cnt_q + 32'd1;
    end else if (accept) begin
      state_d = WAIT_MEM;
      lpend_d = 1'b1;
      lrd_d = in_rd;
      rw_d = in_reg_write;
      f3_d = in_funct3;
      off_d = in_result[1:0];
    end else if (state_q == WAIT_MEM && mem_rvalid) begin
      state_d = IDLE;
      lpend_d = 1'b0;
      cnt_d = cnt_q + 32'd1;
      lerr_d = err;
      we_d = !err && rw_q && lrd_q != '0;
      waddr_d = we_d ? lrd_q : waddr_q;
      wval_d = we_d ? ext : wval_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      lerr_q <= 1'b0;
      lpend_q <= 1'b0;
      waddr_q <= '0;
      wval_q <= '0;
      lrd_q <= '0;
      rw_q <= 1'b0;
      f3_q <= 3'd0;
      off_q <= 2'd0;
      cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      lerr_q <= lerr_d;
      lpend_q <= lpend_d;
      waddr_q <= waddr_d;
      wval_q <= wval_d;
      lrd_q <= lrd_d;
      rw_q <= rw_d;
      f3_q <= f3_d;
      off_q <= off_d;
      cnt_q <= cnt_d;
    end
  end
  assign write_enable = we_q;
  assign write_address = waddr_q;
  assign write_value = wval_q;
  assign load_pending = lpend_q;
  assign load_rd = lrd_q;
  assign load_error = lerr_q;
  assign retired_count = cnt_q;
endmodule
